// File: rtl/accl_pkg.sv
// Shared constants and types for the getAccl pair scheduler and its downstream accumulator.
package accl_pkg;

  localparam int MAX_BODIES = 1024;
  localparam int IDX_W      = 10;
  localparam int PIPE_LAT   = 122;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD_I  = 3'd1,
    LATCH_I = 3'd2,
    STREAM  = 3'd3,
    DRAIN   = 3'd4
  } sched_state_t;

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] idx;
    logic             last;
  } tag_t;

endpackage

// File: rtl/tag_delay_line.sv
// Fixed-depth shift register carrying result tags alongside the getAccl pipeline.
module tag_delay_line #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage_r [DEPTH];

  // Shift one stage per cycle; reset empties the whole line
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) stage_r[k] <= {WIDTH{1'b0}};
    end else begin
      stage_r[0] <= din;
      for (int k = 1; k < DEPTH; k++) stage_r[k] <= stage_r[k-1];
    end
  end

  assign dout = stage_r[DEPTH-1];

endmodule

// File: rtl/accl_pair_sched.sv
// Streams every (i, j != i) body pair into getAccl and tags results for the accumulator.
module accl_pair_sched #(
  parameter int MAX_BODIES = accl_pkg::MAX_BODIES,
  parameter int IDX_W      = accl_pkg::IDX_W,
  parameter int PIPE_LAT   = accl_pkg::PIPE_LAT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [IDX_W:0]   num_bodies,
  input  logic             acc_ready,
  output logic             mem_rd,
  output logic [IDX_W-1:0] mem_addr,
  input  logic [63:0]      mem_x,
  input  logic [63:0]      mem_y,
  input  logic [63:0]      mem_z,
  input  logic [63:0]      mem_m,
  output logic [63:0]      x1,
  output logic [63:0]      y1,
  output logic [63:0]      z1,
  output logic [63:0]      x2,
  output logic [63:0]      y2,
  output logic [63:0]      z2,
  output logic [63:0]      m2,
  output logic             pair_valid,
  output logic             res_valid,
  output logic [IDX_W-1:0] res_idx,
  output logic             res_last,
  output logic             busy,
  output logic             done
);

  import accl_pkg::*;

  localparam int CNT_W = $clog2(PIPE_LAT + 1);
  localparam int TAG_W = IDX_W + 2;
  localparam logic [IDX_W:0] MAX_N = (IDX_W+1)'(MAX_BODIES);

  sched_state_t state_r, state_s;
  logic [IDX_W:0]   n_r, n_in_s, last_j_s;
  logic [IDX_W-1:0] i_r, j_r, j_inc_s, j_next_s, j_first_s, addr_s;
  logic [CNT_W-1:0] drain_r;
  logic             pair_valid_r, pair_last_r, busy_r, done_r;
  logic [IDX_W-1:0] pair_idx_r;
  logic [63:0]      x1_r, y1_r, z1_r;
  logic             rd_s, accept_s, short_s, i_last_s, j_last_s;
  logic [TAG_W-1:0] tag_in_s, tag_out_s;

  // Row/column bookkeeping: clamp N, find the row's final source and the next source skipping i
  always_comb begin
    if (num_bodies > MAX_N) n_in_s = MAX_N;
    else                    n_in_s = num_bodies;
    i_last_s = ({1'b0, i_r} == (n_r - (IDX_W+1)'(1)));
    if (i_last_s) last_j_s = n_r - (IDX_W+1)'(2);
    else          last_j_s = n_r - (IDX_W+1)'(1);
    j_last_s = ({1'b0, j_r} == last_j_s);
    j_inc_s  = j_r + IDX_W'(1'b1);
    if (j_inc_s == i_r) j_next_s = j_inc_s + IDX_W'(1'b1);
    else                j_next_s = j_inc_s;
    if (i_r == {IDX_W{1'b0}}) j_first_s = IDX_W'(1'b1);
    else                      j_first_s = {IDX_W{1'b0}};
  end

  // Next-state and memory-read decode
  always_comb begin
    state_s  = state_r;
    rd_s     = 1'b0;
    addr_s   = {IDX_W{1'b0}};
    accept_s = 1'b0;
    short_s  = 1'b0;
    case (state_r)
      IDLE: begin
        // busy_r still high here means a done cycle, where start is ignored
        if (start && !busy_r) begin
          if (n_in_s < (IDX_W+1)'(2)) begin
            short_s = 1'b1;
          end else begin
            accept_s = 1'b1;
            state_s  = LOAD_I;
          end
        end else begin
          state_s = IDLE;
        end
      end
      LOAD_I: begin
        if (acc_ready) begin
          rd_s    = 1'b1;
          addr_s  = i_r;
          state_s = LATCH_I;
        end else begin
          state_s = LOAD_I;
        end
      end
      LATCH_I: state_s = STREAM;
      STREAM: begin
        rd_s   = 1'b1;
        addr_s = j_r;
        if (j_last_s) begin
          if (i_last_s) state_s = DRAIN;
          else          state_s = LOAD_I;
        end else begin
          state_s = STREAM;
        end
      end
      DRAIN: begin
        if (drain_r == {CNT_W{1'b0}}) state_s = IDLE;
        else                          state_s = DRAIN;
      end
      default: state_s = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_r <= IDLE;
    else      state_r <= state_s;
  end

  // Counters, target latch, pair flags and pass status
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      n_r          <= {(IDX_W+1){1'b0}};
      i_r          <= {IDX_W{1'b0}};
      j_r          <= {IDX_W{1'b0}};
      drain_r      <= {CNT_W{1'b0}};
      x1_r         <= 64'd0;
      y1_r         <= 64'd0;
      z1_r         <= 64'd0;
      pair_valid_r <= 1'b0;
      pair_idx_r   <= {IDX_W{1'b0}};
      pair_last_r  <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      pair_valid_r <= rd_s && (state_r == STREAM);
      pair_idx_r   <= i_r;
      pair_last_r  <= (state_r == STREAM) && j_last_s;
      done_r       <= 1'b0;
      case (state_r)
        IDLE: begin
          busy_r <= accept_s | short_s;
          done_r <= short_s;
          if (accept_s) begin
            n_r <= n_in_s;
            i_r <= {IDX_W{1'b0}};
          end
        end
        LATCH_I: begin
          x1_r <= mem_x;
          y1_r <= mem_y;
          z1_r <= mem_z;
          j_r  <= j_first_s;
        end
        STREAM: begin
          j_r <= j_next_s;
          if (j_last_s) begin
            if (i_last_s) drain_r <= CNT_W'(PIPE_LAT - 1);
            else          i_r <= i_r + IDX_W'(1'b1);
          end
        end
        DRAIN: begin
          if (drain_r == {CNT_W{1'b0}}) done_r <= 1'b1;
          else                          drain_r <= drain_r - CNT_W'(1'b1);
        end
        default: ;
      endcase
    end
  end

  // Tags are zeroed when no pair is in flight so idle results read all-zero
  always_comb begin
    if (pair_valid_r) tag_in_s = {1'b1, pair_idx_r, pair_last_r};
    else              tag_in_s = {TAG_W{1'b0}};
  end

  tag_delay_line #(.DEPTH(PIPE_LAT), .WIDTH(TAG_W)) u_tag_line (
    .clk   (clk),
    .rst_n (rst),
    .din   (tag_in_s),
    .dout  (tag_out_s)
  );

  assign mem_rd     = rd_s;
  assign mem_addr   = addr_s;
  assign x1         = x1_r;
  assign y1         = y1_r;
  assign z1         = z1_r;
  assign x2         = mem_x;
  assign y2         = mem_y;
  assign z2         = mem_z;
  assign m2         = mem_m;
  assign pair_valid = pair_valid_r;
  assign res_valid  = tag_out_s[TAG_W-1];
  assign res_idx    = tag_out_s[IDX_W:1];
  assign res_last   = tag_out_s[0];
  assign busy       = busy_r;
  assign done       = done_r;

endmodule

// File: tb/tb_accl_pair_sched.sv
// Randomized self-checking bench for accl_pair_sched against a pair-order/timing model.
module tb_accl_pair_sched;

  localparam int PIPE_LAT = 122;

  logic        clk = 1'b0;
  logic        rst, start, acc_ready, mem_rd;
  logic [10:0] num_bodies;
  logic [9:0]  mem_addr, res_idx;
  logic [63:0] mem_x, mem_y, mem_z, mem_m;
  logic [63:0] x1, y1, z1, x2, y2, z2, m2;
  logic        pair_valid, res_valid, res_last, busy, done;

  accl_pair_sched dut (
    .clk(clk), .rst(rst), .start(start), .num_bodies(num_bodies), .acc_ready(acc_ready),
    .mem_rd(mem_rd), .mem_addr(mem_addr),
    .mem_x(mem_x), .mem_y(mem_y), .mem_z(mem_z), .mem_m(mem_m),
    .x1(x1), .y1(y1), .z1(z1), .x2(x2), .y2(y2), .z2(z2), .m2(m2),
    .pair_valid(pair_valid), .res_valid(res_valid), .res_idx(res_idx), .res_last(res_last),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct { int i; int j; bit last; int t; } pair_e;
  typedef struct { int i; bit last; int t; } res_e;

  logic [63:0] bx [1024];
  logic [63:0] by [1024];
  logic [63:0] bz [1024];
  logic [63:0] bm [1024];
  pair_e exp_pairs [$];
  res_e  res_q [$];
  int cyc = 0;
  int exp_done_cyc = -1;
  int n_cmp = 0, n_err = 0, n_pv = 0, n_rd = 0;
  bit mon_en = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Body memory: data one cycle after the read strobe, garbage otherwise
  always @(posedge clk) begin
    if (mem_rd) begin
      mem_x <= bx[mem_addr]; mem_y <= by[mem_addr]; mem_z <= bz[mem_addr]; mem_m <= bm[mem_addr];
    end else begin
      mem_x <= {$urandom, $urandom}; mem_y <= {$urandom, $urandom};
      mem_z <= {$urandom, $urandom}; mem_m <= {$urandom, $urandom};
    end
  end

  // Monitor: pairs against the expected order/timing, results PIPE_LAT after each pair
  always @(negedge clk) begin
    pair_e p;
    res_e  r;
    bit    rv;
    if (mon_en) begin
      if (mem_rd) n_rd++;
      if (pair_valid) begin
        n_pv++;
        if (exp_pairs.size() == 0) chk("pair_extra", pair_valid, 1'b0);
        else begin
          p = exp_pairs.pop_front();
          chk("pair_cyc", cyc, p.t);
          chk("x1", x1, bx[p.i]); chk("y1", y1, by[p.i]); chk("z1", z1, bz[p.i]);
          chk("x2", x2, bx[p.j]); chk("y2", y2, by[p.j]); chk("z2", z2, bz[p.j]);
          chk("m2", m2, bm[p.j]);
          r.i = p.i; r.last = p.last; r.t = cyc + PIPE_LAT;
          res_q.push_back(r);
        end
      end
      while (res_q.size() > 0 && res_q[0].t < cyc) void'(res_q.pop_front());
      rv = (res_q.size() > 0) && (res_q[0].t == cyc);
      chk("res_valid", res_valid, rv);
      if (rv) begin
        r = res_q.pop_front();
        chk("res_idx", res_idx, r.i);
        chk("res_last", res_last, r.last);
      end
      chk("done", done, cyc == exp_done_cyc);
      if (cyc == exp_done_cyc) chk("busy_at_done", busy, 1'b1);
    end
  end

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_mem_rd"}, mem_rd, 1'b0);
    chk({tag, "_mem_addr"}, mem_addr, 10'd0);
    chk({tag, "_pair_valid"}, pair_valid, 1'b0);
    chk({tag, "_res_valid"}, res_valid, 1'b0);
    chk({tag, "_res_idx"}, res_idx, 10'd0);
    chk({tag, "_res_last"}, res_last, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_x1"}, x1, 64'd0);
    chk({tag, "_y1"}, y1, 64'd0);
    chk({tag, "_z1"}, z1, 64'd0);
  endtask

  task automatic do_reset_mid();
    rst = 1'b0;
    exp_pairs.delete();
    res_q.delete();
    exp_done_cyc = -1;
    @(negedge clk);
    check_idle_outputs("rst_mid");
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1; start = 1'b0; acc_ready = 1'b1;
    repeat (200) @(posedge clk);
    #1;
  endtask

  // One pass: build the expected pair schedule, drive start/stall/poke/abort, then audit totals
  task automatic run_pass(input int n, input int stall_row, input int stall_len,
                          input bit poke, input int abort_at);
    int s, t, extra, ljr, stall_at;
    n_rd = 0; n_pv = 0;
    @(posedge clk); #1;
    s = cyc;
    t = s;
    for (int i = 0; i < n; i++) begin
      pair_e p;
      extra = (stall_row >= 0 && i >= stall_row) ? stall_len : 0;
      t = s + 4 + i * (n + 1) + extra;
      ljr = (i == n - 1) ? n - 2 : n - 1;
      for (int j = 0; j < n; j++) begin
        if (j != i) begin
          p.i = i; p.j = j; p.last = (j == ljr); p.t = t;
          exp_pairs.push_back(p);
          t++;
        end
      end
    end
    exp_done_cyc = (n < 2) ? s + 1 : t - 1 + PIPE_LAT;
    stall_at = s + 1 + stall_row * (n + 1);
    num_bodies = 11'(n);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    num_bodies = 11'($urandom_range(0, 15));
    while (cyc < exp_done_cyc + 3) begin
      if (abort_at >= 0 && cyc == s + abort_at) begin
        do_reset_mid();
        return;
      end
      if (stall_row >= 0 && cyc == stall_at) acc_ready = 1'b0;
      if (stall_row >= 0 && cyc == stall_at + stall_len) acc_ready = 1'b1;
      if (poke && cyc == s + n + 4) begin
        start = 1'b1;
        num_bodies = 11'($urandom_range(0, 15));
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (cyc == s + 1) chk("busy_start", busy, 1'b1);
      if (acc_ready == 1'b0) chk("stall_rd", mem_rd, 1'b0);
      @(posedge clk); #1;
    end
    chk("pair_count", n_pv, n * (n - 1));
    chk("rd_count", n_rd, (n < 2) ? 0 : n * n);
    @(negedge clk);
    chk("busy_end", busy, 1'b0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, sr, sl;
    bit pk;
    for (int k = 0; k < 1024; k++) begin
      bx[k] = $realtobits(real'(k));
      by[k] = {$urandom, $urandom};
      bz[k] = {$urandom, $urandom};
      bm[k] = {$urandom, $urandom};
    end
    rst = 1'b1; start = 1'b0; acc_ready = 1'b1; num_bodies = 11'd0;
    #3 rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b1;
    mon_en = 1'b1;

    run_pass(3, -1, 0, 1'b0, -1);
    run_pass(2, -1, 0, 1'b0, -1);
    run_pass(1, -1, 0, 1'b0, -1);
    run_pass(0, -1, 0, 1'b0, -1);
    run_pass(4, 2, 10, 1'b0, -1);
    run_pass(3, -1, 0, 1'b0, 7);
    run_pass(3, -1, 0, 1'b0, -1);
    run_pass(3, -1, 0, 1'b1, -1);

    for (int r = 0; r < 5; r++) begin
      n  = $urandom_range(2, 7);
      sr = $urandom_range(0, n);
      if (sr == n) sr = -1;
      sl = $urandom_range(1, 6);
      pk = 1'($urandom_range(0, 1));
      if (sr >= 0 && sr < 2) pk = 1'b0;
      run_pass(n, sr, sl, pk, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/accl_pair_sched.md
Name: accl_pair_sched

Overview:
- Upstream feeder for the getAccl pairwise-acceleration pipeline.
- For each target body i, it reads body i's position once, then streams every other body j (j != i) from body memory into getAccl at one pair per cycle.
- A PIPE_LAT-deep tag delay line travels alongside, so the downstream accumulator knows which i each ax/ay/az result belongs to and when a row ends.
- getAccl has no valid or backpressure of its own; this block is the sole source of result alignment.

Parameters:
- MAX_BODIES, 1024: maximum body count held in body memory.
- IDX_W, 10: body index width; MAX_BODIES <= 2**IDX_W.
- PIPE_LAT, 122: getAccl input-to-output latency in cycles (Add+Mult+Add+InvSqrt+4*Mult = 20+11+20+27+44). Must equal the instantiated getAccl latency.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  begin a full N-body pass; honoured only in IDLE.
- num_bodies  in  IDX_W+1  N; sampled at accepted start.
- acc_ready  in  1  accumulator can accept a new row; checked before each row.
- mem_rd  out  1  body-memory read strobe.
- mem_addr  out  IDX_W  body-memory read address.
- mem_x, mem_y, mem_z, mem_m  in  64 each  body data (IEEE double); valid exactly 1 cycle after mem_rd.
- x1, y1, z1  out  64 each  target-body position, registered.
- x2, y2, z2, m2  out  64 each  source body; mem_* passed straight through.
- pair_valid  out  1  current x1..m2 form a real pair.
- res_valid  out  1  pair_valid delayed PIPE_LAT cycles; aligned with getAccl ax/ay/az.
- res_idx  out  IDX_W  target index i of the current result.
- res_last  out  1  result is the final j of row i.
- busy  out  1  high from accepted start through done cycle inclusive.
- done  out  1  one-cycle pulse at pass completion.

Behaviour:
- Reset (rst=0, async): state=IDLE; all outputs 0; i/j counters 0; tag delay line fully cleared. Reset mid-pass aborts the pass; no partial results are emitted afterwards.
- IDLE: on start=1:
  - N<2: assert done and busy for the next cycle only, issue no reads, stay in IDLE.
  - N>=2: latch N, set i=0, go to LOAD_I.
- LOAD_I:
  - acc_ready=0: wait, with no mem_rd.
  - acc_ready=1: mem_rd=1, mem_addr=i; go to LATCH_I.
- LATCH_I: capture mem_x/y/z into x1/y1/z1. Set j to the first index != i (0, or 1 when i=0). Go to STREAM.
- STREAM: each cycle mem_rd=1, mem_addr=j.
  - Next j skips i.
  - After the last j (N-1, or N-2 when i=N-1): if i==N-1 go to DRAIN, else i++ and go to LOAD_I.
- pair_valid: registered copy of (mem_rd in STREAM).
  - Asserted the cycle the data returns.
  - A pair overlapping the next LOAD_I cycle still uses the old x1 (x1 updates only in LATCH_I).
- Row cost: N+1 cycles when acc_ready=1 (LOAD_I, LATCH_I, N-1 stream cycles).
- Tag line: shift register of {valid, i, last}, width IDX_W+2, depth PIPE_LAT, advanced every cycle. Its input is {pair_valid, i of that pair, pair is last of row}; its output drives res_valid/res_idx/res_last.
- DRAIN: counts down PIPE_LAT cycles from the final pair_valid. done pulses in the same cycle as the final res_valid/res_last, then return to IDLE.
- start while busy: ignored. num_bodies changes mid-pass: ignored.
- Exactly N*(N-1) pair_valid pulses per pass; each row emits exactly one res_last.

Decomposition:
- Package accl_pkg: IDX_W, PIPE_LAT, MAX_BODIES constants, sched_state_t enum (IDLE, LOAD_I, LATCH_I, STREAM, DRAIN), tag_t packed struct {valid, idx, last}.
- One sub-module: tag_delay_line (parameterised depth/width shift register, async active-low clear), reused by the accumulator side.

Test Plan:
- N=3, acc_ready=1, mem body k has x=k.0 -> pairs (0,1),(0,2),(1,0),(1,2),(2,0),(2,1) in order. res_valid pulses exactly 122 cycles after each pair_valid; res_last on (0,2),(1,2),(2,1); done coincides with the last res_valid.
- N=2 -> exactly 2 pairs (0,1),(1,0); busy high from cycle after start to done; total pair_valid count = 2.
- N=1 and N=0 -> done pulses the cycle after start; no mem_rd, pair_valid or res_valid ever asserted.
- N=4, acc_ready held 0 for 10 cycles at row 2 -> LOAD_I stalls with mem_rd=0 for 10 cycles; pair order and res_idx unchanged; 12 pairs total.
- Reset asserted mid-STREAM (row 1), then released -> all outputs 0 immediately; no res_valid for 200 cycles; a new start with N=3 gives the full sequence from the first scenario.
- start pulsed again during STREAM -> ignored; pair sequence and done timing identical to an undisturbed pass.
